// File: rtl/deck_memory.sv
// deck_memory: 52-entry card store with rebuild FSM and unused-card count.
// Serves combinational reads and used-flag writes from card_draw.
module deck_memory #(
    parameter int NUM_CARDS = 52,
    parameter int NUM_RANKS = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] deck_addr,
    input  logic       deck_read_en,
    input  logic       deck_write_en,
    input  logic [6:0] deck_write_data,
    output logic [6:0] deck_read_data,
    input  logic       collect_req,
    output logic       deck_ready,
    output logic [5:0] cards_left,
    output logic       deck_empty
);
    typedef enum logic {S_INIT, S_READY} state_t;

    localparam logic [5:0] LAST_IDX  = 6'(NUM_CARDS - 1);
    localparam logic [5:0] FULL      = 6'(NUM_CARDS);
    localparam logic [3:0] TOP_RANK  = 4'(NUM_RANKS);
    localparam logic [6:0] USED_WORD = 7'h10;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_idx;
    logic [1:0] r_suit;
    logic [3:0] r_rank;
    logic [5:0] r_cards_left;
    logic [6:0] r_mem [NUM_CARDS];

    logic       w_addr_ok;
    logic [5:0] w_ram_addr;
    logic [6:0] w_cur_word;
    logic       w_build_we;
    logic       w_ext_we;
    logic       w_restart;
    logic       w_old_used;
    logic       w_new_used;
    logic       w_unused;

    // Reads are always live, so the read qualifier carries no function.
    assign w_unused   = deck_read_en;
    assign w_addr_ok  = deck_addr < FULL;
    assign w_ram_addr = w_addr_ok ? deck_addr : 6'd0;
    assign w_cur_word = r_mem[w_ram_addr];
    assign w_old_used = w_cur_word[4];
    assign w_new_used = deck_write_data[4];
    assign w_restart  = (r_state == S_READY) && collect_req;

    always_comb begin
        w_next     = r_state;
        w_build_we = 1'b0;
        w_ext_we   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_build_we = 1'b1;
                if (r_idx == LAST_IDX)
                    w_next = S_READY;
            end
            S_READY: begin
                if (collect_req)
                    w_next = S_INIT;
                else
                    w_ext_we = deck_write_en && w_addr_ok;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_INIT;
        else
            r_state <= w_next;
    end

    // Suit and rank step alongside idx so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst || w_restart || (w_build_we && r_idx == LAST_IDX)) begin
            r_idx  <= 6'd0;
            r_suit <= 2'd0;
            r_rank <= 4'd1;
        end else if (w_build_we) begin
            r_idx <= r_idx + 6'd1;
            if (r_rank == TOP_RANK) begin
                r_rank <= 4'd1;
                r_suit <= r_suit + 2'd1;
            end else begin
                r_rank <= r_rank + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_build_we)
                r_mem[r_idx] <= {r_suit, 1'b0, r_rank};
            else if (w_ext_we)
                r_mem[w_ram_addr] <= deck_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_cards_left <= 6'd0;
        end else if (w_build_we) begin
            r_cards_left <= (r_idx == LAST_IDX) ? FULL : 6'd0;
        end else if (w_ext_we) begin
            if (!w_old_used && w_new_used && r_cards_left != 6'd0)
                r_cards_left <= r_cards_left - 6'd1;
            else if (w_old_used && !w_new_used && r_cards_left != FULL)
                r_cards_left <= r_cards_left + 6'd1;
        end
    end

    assign deck_ready     = (r_state == S_READY);
    assign cards_left     = r_cards_left;
    assign deck_empty     = deck_ready && (r_cards_left == 6'd0);
    assign deck_read_data = (deck_ready && w_addr_ok) ? w_cur_word : USED_WORD;
endmodule

// File: tb/tb_deck_memory.sv
// tb_deck_memory: directed checks of build, draw, un-use, exhaustion,
// collect collision and mid-build reset.
module tb_deck_memory;
    logic       clk;
    logic       rst;
    logic [5:0] deck_addr;
    logic       deck_read_en;
    logic       deck_write_en;
    logic [6:0] deck_write_data;
    logic [6:0] deck_read_data;
    logic       collect_req;
    logic       deck_ready;
    logic [5:0] cards_left;
    logic       deck_empty;

    int checks = 0;
    int errors = 0;
    int n;
    int pre;

    deck_memory #(.NUM_CARDS(52), .NUM_RANKS(13)) dut (
        .clk            (clk),
        .rst            (rst),
        .deck_addr      (deck_addr),
        .deck_read_en   (deck_read_en),
        .deck_write_en  (deck_write_en),
        .deck_write_data(deck_write_data),
        .deck_read_data (deck_read_data),
        .collect_req    (collect_req),
        .deck_ready     (deck_ready),
        .cards_left     (cards_left),
        .deck_empty     (deck_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int build_word(input int a);
        return (a / 13) * 32 + (a % 13) + 1;
    endfunction

    task automatic wait_ready(output int edges);
        edges = 0;
        while (edges < 200) begin
            tick();
            edges++;
            if (deck_ready)
                break;
        end
    endtask

    task automatic write(input int addr, input int data);
        deck_addr       = 6'(addr);
        deck_write_data = 7'(data);
        deck_write_en   = 1'b1;
        tick();
        deck_write_en   = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        deck_addr       = 6'd0;
        deck_read_en    = 1'b1;
        deck_write_en   = 1'b0;
        deck_write_data = 7'd0;
        collect_req     = 1'b0;
        tick();
        tick();
        chk("rst_ready", int'(deck_ready), 0);
        chk("rst_left", int'(cards_left), 0);
        chk("rst_empty", int'(deck_empty), 0);
        chk("rst_rdata", int'(deck_read_data), 'h10);

        rst = 1'b0;
        wait_ready(n);
        chk("build_edges", n, 52);
        chk("build_left", int'(cards_left), 52);
        chk("build_empty", int'(deck_empty), 0);
        deck_addr = 6'd0;  #1 chk("rd0", int'(deck_read_data), 'h01);
        deck_addr = 6'd12; #1 chk("rd12", int'(deck_read_data), 'h0D);
        deck_addr = 6'd13; #1 chk("rd13", int'(deck_read_data), 'h21);
        deck_addr = 6'd51; #1 chk("rd51", int'(deck_read_data), 'h6D);
        deck_addr = 6'd52; #1 chk("rd52", int'(deck_read_data), 'h10);

        deck_addr       = 6'd0;
        deck_write_data = 7'h11;
        deck_write_en   = 1'b1;
        #1 chk("rd_before_edge", int'(deck_read_data), 'h01);
        tick();
        deck_write_en = 1'b0;
        chk("draw_word", int'(deck_read_data), 'h11);
        chk("draw_left", int'(cards_left), 51);
        write(0, 'h11);
        chk("redraw_left", int'(cards_left), 51);

        write(0, 'h01);
        deck_addr = 6'd0;
        #1 chk("unuse_word", int'(deck_read_data), 'h01);
        chk("unuse_left", int'(cards_left), 52);
        write(0, 'h01);
        chk("sat_full_left", int'(cards_left), 52);
        write(60, 'h11);
        chk("oob_left", int'(cards_left), 52);
        deck_addr = 6'd60;
        #1 chk("oob_rd", int'(deck_read_data), 'h10);

        for (int i = 0; i < 52; i++)
            write(i, build_word(i) + 'h10);
        chk("exhaust_left", int'(cards_left), 0);
        chk("exhaust_empty", int'(deck_empty), 1);
        deck_addr = 6'd37;
        #1 chk("exhaust_rd37", int'(deck_read_data), build_word(37) + 'h10);
        write(37, build_word(37) + 'h10);
        chk("sat_zero_left", int'(cards_left), 0);

        collect_req = 1'b1;
        tick();
        collect_req = 1'b0;
        chk("collect_ready", int'(deck_ready), 0);
        chk("collect_left", int'(cards_left), 0);
        chk("collect_empty", int'(deck_empty), 0);
        wait_ready(n);
        chk("collect_edges", n, 52);
        chk("collect_full", int'(cards_left), 52);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 52; i++) begin
                deck_addr = 6'(i);
                #1;
                if (int'(deck_read_data) != build_word(i))
                    bad++;
            end
            chk("collect_words_bad", bad, 0);
        end

        deck_addr       = 6'd5;
        deck_write_data = 7'h16;
        deck_write_en   = 1'b1;
        collect_req     = 1'b1;
        tick();
        deck_write_en   = 1'b0;
        collect_req     = 1'b0;
        chk("coll_ready", int'(deck_ready), 0);
        wait_ready(n);
        chk("coll_edges", n, 52);
        deck_addr = 6'd5;
        #1 chk("coll_rd5", int'(deck_read_data), 'h06);
        chk("coll_left", int'(cards_left), 52);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        deck_addr       = 6'd3;
        deck_write_data = 7'h13;
        deck_write_en   = 1'b1;
        repeat (30) tick();
        chk("mid_ready", int'(deck_ready), 0);
        chk("mid_left", int'(cards_left), 0);
        chk("mid_rdata", int'(deck_read_data), 'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        collect_req = 1'b1;
        tick();
        collect_req = 1'b0;
        pre = 6;
        wait_ready(n);
        deck_write_en = 1'b0;
        chk("rebuild_edges", pre + n, 52);
        deck_addr = 6'd3;
        #1 chk("init_write_dropped", int'(deck_read_data), 'h04);
        chk("rebuild_left", int'(cards_left), 52);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/deck_memory.md
# deck_memory

Storage and responder side of the deck memory port driven by `card_draw`. Owns the 52-entry card array and fills it with a fresh, all-unused deck after reset or on request. Serves `card_draw`'s combinational reads and used-flag writes. Tracks how many unused cards remain, so the game controller knows when the shoe is exhausted.

## Interface
Parameters:
- `NUM_CARDS`, 52: number of deck entries; addresses `0..NUM_CARDS-1` are valid.
- `NUM_RANKS`, 13: ranks per suit; valid ranks are `1..NUM_RANKS`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `deck_addr` input 6: entry address from `card_draw`.
- `deck_read_en` input 1: read qualifier from `card_draw`; ignored functionally (reads are always live).
- `deck_write_en` input 1: write strobe from `card_draw`.
- `deck_write_data` input 7: card word to store.
- `deck_read_data` output 7: combinational card word at `deck_addr`.
- `collect_req` input 1: one-cycle pulse requesting a full deck rebuild (all cards back to unused).
- `deck_ready` output 1: high when the deck is built and the port is serviced.
- `cards_left` output 6: count of entries with the used flag clear.
- `deck_empty` output 1: high when `deck_ready` is 1 and `cards_left` is 0.

## Operation
- Card word format:
  - bits [6:5]: suit, 0..3.
  - bit [4]: used flag.
  - bits [3:0]: rank, 1..13.
- Build value for address `a`: suit = `a / 13`, rank = `(a % 13) + 1`, used = 0.
  - `a = 0` → 7'h01; `a = 12` → 7'h0D; `a = 13` → 7'h21; `a = 51` → 7'h6D.
- FSM has two states, INIT and READY.
- INIT:
  - A 6-bit index `idx` walks 0..51, writing one build value per edge.
  - External writes are dropped.
  - `deck_read_data` is forced to 7'h10, so any reader sees the card as used.
  - `deck_ready` = 0 and `cards_left` = 0.
  - On the edge that writes entry 51: go to READY, set `deck_ready` = 1, `cards_left` = 52.
- READY:
  - `deck_read_data` = `mem[deck_addr]` when `deck_addr` < 52; otherwise 7'h10.
  - When `deck_write_en` = 1 and `deck_addr` < 52, `mem[deck_addr]` ← `deck_write_data` on the edge.
  - `cards_left` update, same edge:
    - decrement by 1 if the old bit 4 = 0 and the new bit 4 = 1;
    - increment by 1 if the old bit 4 = 1 and the new bit 4 = 0;
    - otherwise unchanged.
  - Writes with `deck_addr` ≥ 52 are dropped; no counter change.
  - `collect_req` = 1: go to INIT with `idx` = 0, clear `deck_ready` and `cards_left`.
- Boundary rules:
  - `collect_req` and `deck_write_en` in the same READY cycle: collect wins, the write is dropped.
  - `collect_req` during INIT is ignored; the build continues without restarting.
  - `cards_left` saturates at 0 and at 52; it never wraps.
  - A used-flag write to an already-used entry does not change the count.

## Timing
- `rst` high on an edge puts the block in: state INIT, `idx` = 0, `deck_ready` = 0, `cards_left` = 0, `deck_empty` = 0, `deck_read_data` = 7'h10.
- Array contents are not cleared by reset; they are rebuilt by INIT.
- Build latency: entry `k` is written on the (k+1)th edge with `rst` low. `deck_ready` rises after the 52nd such edge.
- A collect rebuild takes 52 edges after the edge that samples `collect_req`; `deck_ready` is low throughout.
- Reads are zero-latency combinational. A read of the address being written in the same cycle returns the old value until the edge.
- `rst` asserted mid-build or mid-game aborts everything and restarts INIT from `idx` = 0 on the following edges.
- `deck_empty` is purely combinational from `deck_ready` and `cards_left`.

## Test plan
- Reset, then release:
  - `deck_ready` rises exactly 52 edges after release.
  - `cards_left` = 52.
  - Reads at 0 / 12 / 13 / 51 return 7'h01 / 7'h0D / 7'h21 / 7'h6D.
  - Read at 52 returns 7'h10.
- Draw path: write 7'h11 to addr 0 → `mem[0]` = 7'h11, `cards_left` = 51. Write 7'h11 to addr 0 again → `cards_left` stays 51.
- Un-use path: write 7'h01 to addr 0 → `cards_left` = 52. A write to addr 60 changes no entry and no count.
- Exhaustion: set the used flag on all 52 entries → `cards_left` = 0, `deck_empty` = 1. `collect_req` pulse → `deck_ready` = 0 for 52 edges, then all entries unused and `cards_left` = 52.
- Collision: `collect_req` and a write to addr 5 in the same cycle → write dropped, rebuild starts. After the rebuild, `mem[5]` = 7'h06.
- Mid-build reset:
  - Assert `rst` at `idx` = 30 → `deck_ready` rises 52 edges after re-release, not earlier.
  - Writes during INIT are ignored.
  - `collect_req` during INIT does not extend the build.
